// File: rtl/msx_joy_router.sv
// Routes host joystick words onto active-low MSX joystick ports with rotation,
// opposite-direction suppression and per-port fire1 autofire; outputs registered.
module msx_joy_router #(
    parameter int NUM_JOY = 2,
    parameter int JOY_W   = 16,
    parameter int AF_DIV  = 1073863
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [NUM_JOY*JOY_W-1:0]   joy_i,
    input  logic [$clog2(NUM_JOY)-1:0] map_sel_i,
    input  logic [NUM_JOY-1:0]         af_en_i,
    output logic [NUM_JOY*6-1:0]       joy_n_o
);
    localparam int MW = $clog2(NUM_JOY);
    localparam int CW = $clog2(AF_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(AF_DIV - 1);

    logic [MW-1:0]        r_map;
    logic                 r_first;
    logic [CW-1:0]        r_cnt [NUM_JOY];
    logic [NUM_JOY-1:0]   r_ph;
    logic [NUM_JOY*6-1:0] r_out;

    logic [MW-1:0]        w_map;
    logic                 w_guard;
    logic [CW-1:0]        w_cnt_nxt [NUM_JOY];
    logic [NUM_JOY-1:0]   w_ph_nxt;
    logic [NUM_JOY*6-1:0] w_pins;

    // Out-of-range selections fold to 0; the first cycle after reset takes the
    // mapping directly instead of treating it as a change.
    always_comb begin
        w_map   = (int'(map_sel_i) >= NUM_JOY) ? '0 : map_sel_i;
        w_guard = !r_first && (w_map != r_map);
    end

    always_comb begin
        logic [JOY_W-1:0] w_word;
        logic             w_up, w_dn, w_lf, w_rt, w_f1, w_p6;
        int               w_src;
        w_word   = '0;
        w_up     = 1'b0;
        w_dn     = 1'b0;
        w_lf     = 1'b0;
        w_rt     = 1'b0;
        w_f1     = 1'b0;
        w_p6     = 1'b0;
        w_src    = 0;
        w_pins   = '1;
        w_ph_nxt = r_ph;
        for (int k = 0; k < NUM_JOY; k++) begin
            w_src  = (k + int'(w_map)) % NUM_JOY;
            w_word = joy_i[w_src*JOY_W +: JOY_W];
            w_up   = w_word[3] & ~w_word[2];
            w_dn   = w_word[2] & ~w_word[3];
            w_lf   = w_word[1] & ~w_word[0];
            w_rt   = w_word[0] & ~w_word[1];
            w_f1   = w_word[4];
            w_cnt_nxt[k] = '0;
            // r_ph = 1 means the autofire pulse is in its pressed half.
            if (w_f1 && af_en_i[k]) begin
                w_p6 = r_ph[k];
                if (r_cnt[k] == CNT_LAST) begin
                    w_ph_nxt[k] = ~r_ph[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + 1'b1;
                end
            end else begin
                w_p6        = w_f1;
                w_ph_nxt[k] = 1'b1;
            end
            w_pins[k*6 +: 6] = ~{w_word[5], w_p6, w_up, w_dn, w_lf, w_rt};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out   <= '1;
            r_map   <= '0;
            r_first <= 1'b1;
            r_ph    <= '1;
            for (int k = 0; k < NUM_JOY; k++) r_cnt[k] <= '0;
        end else begin
            r_first <= 1'b0;
            r_map   <= w_map;
            if (w_guard) begin
                r_out <= '1;
                r_ph  <= '1;
                for (int k = 0; k < NUM_JOY; k++) r_cnt[k] <= '0;
            end else begin
                r_out <= w_pins;
                r_ph  <= w_ph_nxt;
                for (int k = 0; k < NUM_JOY; k++) r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    assign joy_n_o = r_out;

endmodule

// File: tb/tb_msx_joy_router.sv
// Bench for msx_joy_router: directed scenarios plus randomized traffic against
// a cycle-count based reference model (2-port instance) and a 3-port rotation check.
module tb_msx_joy_router;
    localparam int N  = 2;
    localparam int AF = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] joy;
    logic [0:0]  map_sel;
    logic [1:0]  af_en;
    logic [11:0] joy_n;

    logic [47:0] joy3;
    logic [1:0]  map3;
    logic [2:0]  af3;
    logic [17:0] joy_n3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] m_exp;
    logic        m_first;
    int          m_map;
    int          m_hold [N];

    msx_joy_router #(.NUM_JOY(N), .JOY_W(16), .AF_DIV(AF)) dut (
        .clk_sys(clk), .reset(reset), .joy_i(joy), .map_sel_i(map_sel),
        .af_en_i(af_en), .joy_n_o(joy_n)
    );

    msx_joy_router #(.NUM_JOY(3), .JOY_W(16), .AF_DIV(2)) dut3 (
        .clk_sys(clk), .reset(reset), .joy_i(joy3), .map_sel_i(map3),
        .af_en_i(af3), .joy_n_o(joy_n3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Autofire modelled as elapsed hold time: pressed during even AF-length windows.
    task automatic model_update();
        int          mi, src;
        logic [15:0] w;
        logic        up, dn, lf, rt, p6, f1;
        if (reset) begin
            m_exp   = '1;
            m_first = 1'b1;
            m_map   = 0;
            for (int k = 0; k < N; k++) m_hold[k] = 0;
        end else begin
            mi = (int'(map_sel) >= N) ? 0 : int'(map_sel);
            if (!m_first && mi != m_map) begin
                m_exp = '1;
                for (int k = 0; k < N; k++) m_hold[k] = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    src = (k + mi) % N;
                    w   = joy[src*16 +: 16];
                    up  = w[3] && !w[2];
                    dn  = w[2] && !w[3];
                    lf  = w[1] && !w[0];
                    rt  = w[0] && !w[1];
                    f1  = w[4];
                    if (f1 && af_en[k]) begin
                        p6 = ((m_hold[k] / AF) % 2) == 0;
                        m_hold[k]++;
                    end else begin
                        p6 = f1;
                        m_hold[k] = 0;
                    end
                    m_exp[k*6 +: 6] = ~{w[5], p6, up, dn, lf, rt};
                end
            end
            m_map   = mi;
            m_first = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [11:0] p0_fire(input logic low);
        return {6'h3F, 1'b1, ~low, 4'hF};
    endfunction

    initial begin
        reset   = 1'b1;
        joy     = '0;
        map_sel = '0;
        af_en   = '0;
        joy3    = {16'h0008, 16'h0002, 16'h0001};
        map3    = 2'd2;
        af3     = '0;
        step();
        step();
        chk("reset_out", 32'(joy_n), 32'hFFF);
        chk("reset_out3", 32'(joy_n3), 32'h3FFFF);

        reset = 1'b0;
        joy   = 32'h0000_0008;
        step();
        chk("up_map0", 32'(joy_n), 32'({6'b111111, 6'b110111}));
        chk("rot3_first", 32'(joy_n3), 32'({6'b111101, 6'b111110, 6'b110111}));

        map3 = 2'd3;
        joy  = 32'h0000_000C;
        step();
        chk("ud_suppress", 32'(joy_n), 32'hFFF);
        chk("rot3_guard", 32'(joy_n3), 32'h3FFFF);
        joy = 32'h0000_0003;
        step();
        chk("lr_suppress", 32'(joy_n), 32'hFFF);
        chk("rot3_sel3", 32'(joy_n3), 32'({6'b110111, 6'b111101, 6'b111110}));

        joy = 32'h0000_0001;
        step();
        chk("right_map0", 32'(joy_n), 32'({6'b111111, 6'b111110}));
        map_sel = 1'b1;
        step();
        chk("swap_guard", 32'(joy_n), 32'hFFF);
        step();
        chk("swap_new", 32'(joy_n), 32'({6'b111110, 6'b111111}));
        map_sel = 1'b0;
        joy     = '0;
        af_en   = 2'b01;
        step();
        step();

        joy = 32'h0000_0010;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("af_held", 32'(joy_n), 32'(p0_fire(((i / AF) % 2) == 0)));
        end
        joy = '0;
        step();
        joy = 32'h0000_0010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("af_pre_rel", 32'(joy_n), 32'(p0_fire(i < AF)));
        end
        joy = '0;
        step();
        chk("af_release", 32'(joy_n), 32'hFFF);
        joy = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("af_repress", 32'(joy_n), 32'(p0_fire(i < AF)));
        end

        af_en = 2'b00;
        step();
        chk("af_off_follow", 32'(joy_n), 32'(p0_fire(1'b1)));
        af_en = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("af_reenable", 32'(joy_n), 32'(p0_fire(i < AF)));
        end

        map_sel = 1'b1;
        joy     = 32'h0010_0000;
        af_en   = 2'b11;
        step();
        chk("rst_pre_guard", 32'(joy_n), 32'hFFF);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_af", 32'(joy_n), 32'hFFF);
        reset = 1'b0;
        step();
        chk("rst_no_guard", 32'(joy_n), 32'({6'h3F, 6'b101111}));
        for (int i = 1; i < 5; i++) step();
        chk("rst_af_fresh", 32'(joy_n), 32'({6'h3F, 6'b111111}));

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) joy[15:0]  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) joy[31:16] = 16'($urandom);
            if ($urandom_range(0, 15) == 0) map_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) af_en = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 59) == 0);
            step();
            chk("rand", 32'(joy_n), 32'(m_exp));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/msx_joy_router.md
MSX_JOY_ROUTER -- requirements
Module: msx_joy_router

Parameters
REQ-001 NUM_JOY, 2, number of host joystick inputs and MSX joystick ports (range 2..4).
REQ-002 JOY_W, 16, width of each host joystick word.
REQ-003 AF_DIV, 1073863, autofire half-period in clk_sys cycles (minimum 2).

Interface
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 joy_i  in  NUM_JOY*JOY_W  host joystick words, active-high; word k at [k*JOY_W +: JOY_W]; bit0 right, bit1 left, bit2 down, bit3 up, bit4 fire1, bit5 fire2.
REQ-007 map_sel_i  in  clog2(NUM_JOY)  port rotation; values >= NUM_JOY treated as 0.
REQ-008 af_en_i  in  NUM_JOY  per-output-port autofire enable for fire1.
REQ-009 joy_n_o  out  NUM_JOY*6  MSX port k at [6k +: 6] = {p9,p6,up,down,left,right}, active-low.

Function
REQ-010 Output port k SHALL source host word (k + map_sel) mod NUM_JOY; with NUM_JOY=2, map_sel=1 is the legacy swap.
REQ-011 The pin mapping SHALL be: right<-bit0, left<-bit1, down<-bit2, up<-bit3, p6<-fire1, p9<-fire2, each inverted.
REQ-012 joy_n_o SHALL be registered, with 1 cycle latency from joy_i to output.
REQ-013 Opposite directions SHALL be suppressed: up+down both pressed -> both released (1); left+right both pressed -> both released.
REQ-014 map_sel_i SHALL be registered internally; on a change of the registered value, all outputs SHALL be forced to 6'b111111 for exactly one cycle, and the new mapping SHALL appear on the following cycle.
REQ-015 Each port SHALL own an autofire counter (clog2(AF_DIV) bits) and a phase bit.
REQ-016 While fire1 of the sourced word is released, or af_en_i[k]=0: counter=0, phase=pressed, p6 follows fire1 directly.
REQ-017 While fire1 is held and af_en_i[k]=1: counter increments each cycle; at AF_DIV-1 it wraps to 0 and phase toggles; p6 = phase (pressed drives 0).
REQ-018 First autofire pulse SHALL be pressed for exactly AF_DIV cycles after the press edge, then alternate in AF_DIV-cycle halves.
REQ-019 Fire release mid-pulse SHALL clear the counter and release p6 on the next registered output.
REQ-020 A mapping change (REQ-014) SHALL clear all autofire counters and phases.
REQ-021 Toggling af_en_i while fire1 is held SHALL restart the sequence from REQ-018 on re-enable.
REQ-022 fire2/p9 SHALL never autofire.
REQ-023 Bits above bit5 of each joy_i word SHALL be ignored.

Reset
REQ-024 While reset=1: joy_n_o = all ones, counters = 0, phases = pressed, registered map_sel = 0.
REQ-025 The first cycle after reset deasserts SHALL NOT generate the REQ-014 guard cycle, even if map_sel_i != 0; the mapping is taken directly.
REQ-026 Reset asserted mid-autofire SHALL take effect on the next edge and override all other behaviour.

Verification (NUM_JOY=2, AF_DIV=4 unless stated)
REQ-027 joy_i word0=16'h0008, map_sel=0 -> joy_n_o[5:0]=6'b110111 one cycle later; port1=6'b111111.
REQ-028 map_sel 0->1 with word0=16'h0001 held -> one cycle of joy_n_o all ones, then port1=6'b111110 and port0=6'b111111.
REQ-029 word0=16'h000C (up+down) -> port0=6'b111111; word0=16'h0003 -> port0=6'b111111.
REQ-030 af_en=2'b01, word0=16'h0010 held 20 cycles -> port0 p6 low for 4 cycles, high for 4, low for 4, ...; release at cycle 6 -> p6 high next cycle, counter 0.
REQ-031 Reset asserted during autofire with map_sel=1 -> all ones; after deassert, port0 reflects word1 with no guard cycle.
REQ-032 NUM_JOY=3, map_sel=2 -> port0<-word2, port1<-word0, port2<-word1; map_sel=3 behaves as 0.
